// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: one 128-bit cache line moved as a single 4-beat 32-bit AXI4 INCR burst.
// One transaction in flight at a time; writebacks win over refills when both are pending.
module cache_axi_bridge #(
    parameter logic [4:0] AXI_ID = 5'd0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         wr_req_i,
    input  logic [31:0]  wr_addr_i,
    input  logic [127:0] wr_data_i,
    input  logic [15:0]  wr_strb_i,
    output logic         wr_ready_o,
    output logic         wr_done_o,
    input  logic         rd_req_i,
    input  logic [31:0]  rd_addr_i,
    output logic         rd_ready_o,
    output logic         rd_valid_o,
    output logic [127:0] rd_data_o,
    output logic         err_o,
    output logic         outport_awvalid_o,
    output logic [31:0]  outport_awaddr_o,
    output logic [4:0]   outport_awid_o,
    output logic [7:0]   outport_awlen_o,
    output logic [1:0]   outport_awburst_o,
    input  logic         outport_awready_i,
    output logic         outport_wvalid_o,
    output logic [31:0]  outport_wdata_o,
    output logic [3:0]   outport_wstrb_o,
    output logic         outport_wlast_o,
    input  logic         outport_wready_i,
    input  logic         outport_bvalid_i,
    input  logic [1:0]   outport_bresp_i,
    input  logic [4:0]   outport_bid_i,
    output logic         outport_bready_o,
    output logic         outport_arvalid_o,
    output logic [31:0]  outport_araddr_o,
    output logic [4:0]   outport_arid_o,
    output logic [7:0]   outport_arlen_o,
    output logic [1:0]   outport_arburst_o,
    input  logic         outport_arready_i,
    input  logic         outport_rvalid_i,
    input  logic [31:0]  outport_rdata_i,
    input  logic [1:0]   outport_rresp_i,
    input  logic [4:0]   outport_rid_i,
    input  logic         outport_rlast_i,
    output logic         outport_rready_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [3:0][31:0] r_wdata;
    logic [3:0][3:0]  r_wstrb;
    logic [3:0][31:0] r_line;
    logic [3:0][31:0] r_rd_data;
    logic [1:0]       r_beat;
    logic             r_aw_done;
    logic             r_w_done;
    logic             r_err;
    logic             r_awvalid;
    logic             r_wvalid;
    logic             r_arvalid;
    logic             r_bready;
    logic             r_rready;
    logic             r_wr_done;
    logic             r_rd_valid;
    logic             r_err_o;

    logic             w_idle;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_aw_ok;
    logic             w_w_ok;
    logic             w_r_hs;
    logic             w_r_end;
    logic             w_r_bad;
    logic [3:0][31:0] w_line_next;
    logic             w_unused;

    assign w_idle     = (r_state == S_IDLE);
    assign wr_ready_o = rst_ni & w_idle & wr_req_i;
    assign rd_ready_o = rst_ni & w_idle & rd_req_i & ~wr_req_i;

    assign w_aw_hs = r_awvalid & outport_awready_i;
    assign w_w_hs  = r_wvalid & outport_wready_i;
    assign w_aw_ok = r_aw_done | w_aw_hs;
    assign w_w_ok  = r_w_done | (w_w_hs & (r_beat == 2'd3));
    assign w_r_hs  = r_rready & outport_rvalid_i;
    assign w_r_end = outport_rlast_i | (r_beat == 2'd3);
    // Early or missing rlast is flagged but the burst still ends on time.
    assign w_r_bad = (outport_rresp_i != 2'b00)
                   | (outport_rlast_i != (r_beat == 2'd3));

    always_comb begin
        w_line_next         = r_line;
        w_line_next[r_beat] = outport_rdata_i;
    end

    assign w_unused = ^{outport_bid_i, outport_rid_i,
                        wr_addr_i[3:0], rd_addr_i[3:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_line     <= '0;
            r_rd_data  <= '0;
            r_beat     <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_err      <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_bready   <= 1'b0;
            r_rready   <= 1'b0;
            r_wr_done  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_err_o    <= 1'b0;
        end else begin
            r_wr_done  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_err_o    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (wr_req_i) begin
                        r_addr    <= {wr_addr_i[31:4], 4'b0};
                        r_wdata   <= wr_data_i;
                        r_wstrb   <= wr_strb_i;
                        r_beat    <= '0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WR_REQ;
                    end else if (rd_req_i) begin
                        r_addr    <= {rd_addr_i[31:4], 4'b0};
                        r_beat    <= '0;
                        r_arvalid <= 1'b1;
                        r_state   <= S_RD_ADDR;
                    end
                end
                S_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == 2'd3) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (outport_bvalid_i) begin
                        r_bready  <= 1'b0;
                        r_wr_done <= 1'b1;
                        r_err_o   <= r_err | (outport_bresp_i != 2'b00);
                        r_state   <= S_DONE;
                    end
                end
                S_RD_ADDR: begin
                    if (outport_arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_line <= w_line_next;
                        r_beat <= r_beat + 2'd1;
                        if (w_r_bad)
                            r_err <= 1'b1;
                        if (w_r_end) begin
                            r_rready   <= 1'b0;
                            r_rd_data  <= w_line_next;
                            r_rd_valid <= 1'b1;
                            r_err_o    <= r_err | w_r_bad;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign outport_awvalid_o = r_awvalid;
    assign outport_awaddr_o  = r_addr;
    assign outport_awid_o    = AXI_ID;
    assign outport_awlen_o   = 8'd3;
    assign outport_awburst_o = 2'b01;
    assign outport_wvalid_o  = r_wvalid;
    assign outport_wdata_o   = r_wdata[r_beat];
    assign outport_wstrb_o   = r_wstrb[r_beat];
    assign outport_wlast_o   = r_wvalid & (r_beat == 2'd3);
    assign outport_bready_o  = r_bready;
    assign outport_arvalid_o = r_arvalid;
    assign outport_araddr_o  = r_addr;
    assign outport_arid_o    = AXI_ID;
    assign outport_arlen_o   = 8'd3;
    assign outport_arburst_o = 2'b01;
    assign outport_rready_o  = r_rready;
    assign wr_done_o         = r_wr_done;
    assign rd_valid_o        = r_rd_valid;
    assign rd_data_o         = r_rd_data;
    assign err_o             = r_err_o;
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Bench for cache_axi_bridge: AXI slave with memory plus a line-level reference memory.
// Directed latency/priority/error/reset cases, then 200 randomly stalled transactions.
module tb_cache_axi_bridge;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_req_i = 1'b0;
    logic [31:0]  wr_addr_i = '0;
    logic [127:0] wr_data_i = '0;
    logic [15:0]  wr_strb_i = '0;
    logic         wr_ready_o, wr_done_o;
    logic         rd_req_i = 1'b0;
    logic [31:0]  rd_addr_i = '0;
    logic         rd_ready_o, rd_valid_o, err_o;
    logic [127:0] rd_data_o;
    logic         awvalid, awready = 1'b0;
    logic [31:0]  awaddr;
    logic [4:0]   awid;
    logic [7:0]   awlen;
    logic [1:0]   awburst;
    logic         wvalid, wready = 1'b0, wlast;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         bvalid = 1'b0, bready;
    logic [1:0]   bresp = 2'b00;
    logic [4:0]   bid = 5'd0;
    logic         arvalid, arready = 1'b0;
    logic [31:0]  araddr;
    logic [4:0]   arid;
    logic [7:0]   arlen;
    logic [1:0]   arburst;
    logic         rvalid = 1'b0, rready, rlast = 1'b0;
    logic [31:0]  rdata = '0;
    logic [1:0]   rresp = 2'b00;
    logic [4:0]   rid = 5'd0;

    always #5 clk = ~clk;

    cache_axi_bridge #(.AXI_ID(5'd0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_strb_i(wr_strb_i), .wr_ready_o(wr_ready_o), .wr_done_o(wr_done_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .err_o(err_o),
        .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr),
        .outport_awid_o(awid), .outport_awlen_o(awlen),
        .outport_awburst_o(awburst), .outport_awready_i(awready),
        .outport_wvalid_o(wvalid), .outport_wdata_o(wdata),
        .outport_wstrb_o(wstrb), .outport_wlast_o(wlast),
        .outport_wready_i(wready),
        .outport_bvalid_i(bvalid), .outport_bresp_i(bresp),
        .outport_bid_i(bid), .outport_bready_o(bready),
        .outport_arvalid_o(arvalid), .outport_araddr_o(araddr),
        .outport_arid_o(arid), .outport_arlen_o(arlen),
        .outport_arburst_o(arburst), .outport_arready_i(arready),
        .outport_rvalid_i(rvalid), .outport_rdata_i(rdata),
        .outport_rresp_i(rresp), .outport_rid_i(rid),
        .outport_rlast_i(rlast), .outport_rready_o(rready)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line-level reference memory and the slave's word memory
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    function automatic logic [31:0] seed(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : seed(a);
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:4], 4'b0};
        return {ref_rd(b + 12), ref_rd(b + 8), ref_rd(b + 4), ref_rd(b)};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [127:0] d,
                             input logic [15:0] s);
        logic [31:0] b, w;
        b = {a[31:4], 4'b0};
        for (int n = 0; n < 4; n++) begin
            w = ref_rd(b + 32'(4 * n));
            for (int k = 0; k < 4; k++)
                if (s[4 * n + k]) w[8 * k +: 8] = d[32 * n + 8 * k +: 8];
            ref_mem[b + 32'(4 * n)] = w;
        end
    endtask

    // Slave state: mode 0 zero-wait, 1 random stalls, 2 awready held until 3 cycles after W
    int          mode = 0;
    bit          rerr = 1'b0;
    bit          aw_seen, b_pend, b_hold, r_active, r_hold;
    logic [31:0] aw_addr, ar_addr;
    int          w_cnt, aw_wait, r_beat;
    logic [31:0] w_buf [4];
    logic [3:0]  s_buf [4];
    int          aw_cnt = 0, w_tot = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    logic        p_wlast;

    task automatic slave_clear();
        aw_seen = 0; b_pend = 0; b_hold = 0; r_active = 0; r_hold = 0;
        w_cnt = 0; aw_wait = 0; r_beat = 0;
        p_aw = 0; p_w = 0; p_ar = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        rlast = 0; rresp = 2'b00; rdata = '0;
    endtask

    function automatic bit coin();
        return (mode != 1) || ($urandom_range(0, 2) != 0);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            slave_clear();
        end else begin
            if (p_aw) chk("aw_hold", 128'({awvalid, awaddr}), 128'({1'b1, p_awaddr}));
            if (p_w)
                chk("w_hold", 128'({wvalid, wdata, wstrb, wlast}),
                    128'({1'b1, p_wdata, p_wstrb, p_wlast}));
            if (p_ar) chk("ar_hold", 128'({arvalid, araddr}), 128'({1'b1, p_araddr}));
            if (mode == 2 && w_cnt == 4 && !aw_seen) aw_wait++;
            awready = (mode == 2) ? (w_cnt == 4 && aw_wait >= 3) : coin();
            wready  = coin();
            arready = coin();
            if (!b_hold) bvalid = b_pend && coin();
            if (!r_hold) rvalid = r_active && coin();
            rdata = slv_rd(ar_addr + 32'(4 * r_beat));
            rlast = (r_beat == 3);
            rresp = (rerr && r_beat == 1) ? 2'b10 : 2'b00;
            // Handshakes below complete at the coming posedge
            if (bvalid && bready) begin
                b_pend = 0; aw_seen = 0; w_cnt = 0; aw_wait = 0; b_cnt++;
            end
            b_hold = bvalid && !bready;
            if (awvalid && awready) begin
                aw_seen = 1; aw_addr = awaddr; aw_cnt++;
                chk("aw_attr", 128'({awlen, awburst, awid}), 128'({8'd3, 2'b01, 5'd0}));
            end
            if (wvalid && wready && w_cnt < 4) begin
                w_buf[w_cnt] = wdata; s_buf[w_cnt] = wstrb;
                chk("wlast", 128'(wlast), 128'(w_cnt == 3));
                w_cnt++; w_tot++;
            end
            if (aw_seen && w_cnt == 4 && !b_pend) begin
                for (int n = 0; n < 4; n++) begin
                    logic [31:0] w;
                    w = slv_rd(aw_addr + 32'(4 * n));
                    for (int k = 0; k < 4; k++)
                        if (s_buf[n][k]) w[8 * k +: 8] = w_buf[n][8 * k +: 8];
                    slv_mem[aw_addr + 32'(4 * n)] = w;
                end
                b_pend = 1;
            end
            if (rvalid && rready) begin
                r_beat++; r_cnt++;
                if (r_beat == 4) begin r_active = 0; r_beat = 0; end
            end
            r_hold = rvalid && !rready;
            if (arvalid && arready) begin
                r_active = 1; ar_addr = araddr; r_beat = 0; ar_cnt++;
                chk("ar_attr", 128'({arlen, arburst, arid}), 128'({8'd3, 2'b01, 5'd0}));
            end
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_wdata = wdata;
            p_wstrb = wstrb; p_wlast = wlast;
            p_ar = arvalid && !arready; p_araddr = araddr;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, 128'({awvalid, wvalid, arvalid, bready, rready, wr_done_o,
                       rd_valid_o, err_o, wr_ready_o, rd_ready_o}), 128'(0));
        chk({tag, "_data"}, rd_data_o, 128'(0));
    endtask

    task automatic finish_wr(input logic exp_err, output int lat);
        int n;
        step();
        wr_req_i = 0;
        n = 1;
        while (!wr_done_o && n < 400) begin step(); n++; end
        lat = n;
        chk("wr_done", 128'(wr_done_o), 128'(1));
        chk("wr_err", 128'(err_o), 128'(exp_err));
        chk("busy_in_done", 128'({wr_ready_o, rd_ready_o}), 128'(0));
        step();
        chk("wr_pulse", 128'({wr_done_o, err_o}), 128'(0));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [127:0] d,
                            input logic [15:0] s, output int lat);
        int n;
        wr_addr_i = a; wr_data_i = d; wr_strb_i = s; wr_req_i = 1;
        #1;
        n = 0;
        while (!wr_ready_o && n < 400) begin step(); n++; end
        chk("wr_accept", 128'(wr_ready_o), 128'(1));
        ref_write(a, d, s);
        finish_wr(1'b0, lat);
    endtask

    task automatic finish_rd(input logic [127:0] exp, input logic exp_err,
                             output int lat);
        int n;
        step();
        rd_req_i = 0;
        n = 1;
        while (!rd_valid_o && n < 400) begin step(); n++; end
        lat = n;
        chk("rd_valid", 128'(rd_valid_o), 128'(1));
        chk("rd_data", rd_data_o, exp);
        chk("rd_err", 128'(err_o), 128'(exp_err));
        chk("busy_in_done", 128'({wr_ready_o, rd_ready_o}), 128'(0));
        step();
        chk("rd_pulse", 128'({rd_valid_o, err_o}), 128'(0));
        chk("rd_hold", rd_data_o, exp);
    endtask

    task automatic do_read(input logic [31:0] a, input logic exp_err,
                           output int lat);
        int n;
        rd_addr_i = a; rd_req_i = 1;
        #1;
        n = 0;
        while (!rd_ready_o && n < 400) begin step(); n++; end
        chk("rd_accept", 128'(rd_ready_o), 128'(1));
        finish_rd(ref_line(a), exp_err, lat);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0, w0, r0, b0;
        logic [127:0] line;
        for (int n = 0; n < 4; n++) begin
            slv_mem[32'h1000 + 32'(4 * n)] = 32'(8'h11 * (n + 1));
            ref_mem[32'h1000 + 32'(4 * n)] = 32'(8'h11 * (n + 1));
        end
        step(); step();
        chk_reset_outs("reset_state");
        rst_n = 1;
        step();

        // Zero-wait read with unaligned address
        mode = 0;
        do_read(32'h0000_1004, 1'b0, lat);
        chk("t1_lat", 128'(lat), 128'(6));
        chk("t1_araddr", 128'(ar_addr), 128'(32'h1000));
        chk("t1_line", rd_data_o, 128'h00000044_00000033_00000022_00000011);

        // Zero-wait write latency
        do_write(32'h3000, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 16'hFFFF, lat);
        chk("wr_lat", 128'(lat), 128'(6));

        // awready held until after all W beats
        mode = 2;
        a0 = aw_cnt; w0 = w_tot; b0 = b_cnt;
        do_write(32'h2000, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hF0FF, lat);
        chk("t2_aw_once", 128'(aw_cnt - a0), 128'(1));
        chk("t2_w_beats", 128'(w_tot - w0), 128'(4));
        chk("t2_b_once", 128'(b_cnt - b0), 128'(1));
        chk("t2_wstrb", 128'({s_buf[3], s_buf[2], s_buf[1], s_buf[0]}), 128'(16'hF0FF));
        mode = 0;
        do_read(32'h2000, 1'b0, lat);

        // Simultaneous requests: write first, read right after DONE
        wr_addr_i = 32'h3010; wr_data_i = {4{32'hCAFE_0001}}; wr_strb_i = 16'hFFFF;
        rd_addr_i = 32'h3010;
        wr_req_i = 1; rd_req_i = 1;
        #1;
        chk("prio", 128'({wr_ready_o, rd_ready_o}), 128'(2'b10));
        ref_write(32'h3010, {4{32'hCAFE_0001}}, 16'hFFFF);
        finish_wr(1'b0, lat);
        chk("t3_rd_after_done", 128'(rd_ready_o), 128'(1));
        finish_rd(ref_line(32'h3010), 1'b0, lat);

        // rresp error on beat 1
        r0 = r_cnt;
        rerr = 1;
        do_read(32'h1000, 1'b1, lat);
        rerr = 0;
        chk("t5_beats", 128'(r_cnt - r0), 128'(4));
        do_read(32'h2000, 1'b0, lat);

        // Reset during read beat 2
        r0 = r_cnt;
        rd_addr_i = 32'h3000; rd_req_i = 1;
        for (int n = 0; n < 40 && (r_cnt - r0) < 3; n++) step();
        chk("t6_reached_beat2", 128'(r_cnt - r0), 128'(3));
        rst_n = 0;
        #1;
        chk_reset_outs("t6_async_reset");
        rd_req_i = 0;
        step(); step();
        rst_n = 1;
        step();
        do_read(32'h1000, 1'b0, lat);
        chk("t6_fresh_lat", 128'(lat), 128'(6));

        // Random stalls and traffic
        mode = 1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = 32'h8000 + 32'($urandom_range(0, 15) << 4) + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                line = {$urandom, $urandom, $urandom, $urandom};
                do_write(a, line, 16'($urandom), lat);
            end else begin
                do_read(a, 1'b0, lat);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Cache-line bridge sitting directly upstream of the DDR3 AXI controller. It takes one 128-bit line refill or writeback request at a time from the CPU cache. It issues it as a single 4-beat, 32-bit AXI4 INCR burst on the controller's AXI slave port. It returns the assembled line, or write completion, to the cache.

## Interface
- AXI_ID, default 0: 5-bit value driven on awid/arid.
- clk_i  in  1  single clock for all logic.
- rst_ni  in  1  asynchronous, active-low reset.
- wr_req_i  in  1  writeback request, held until accepted.
- wr_addr_i  in  32  line address; bits [3:0] are ignored and forced to zero.
- wr_data_i  in  128  line data; word n is bits [32n+31:32n].
- wr_strb_i  in  16  byte enables; beat n uses bits [4n+3:4n].
- wr_ready_o  out  1  accept strobe for the write request.
- wr_done_o  out  1  one-cycle pulse when the write response is received.
- rd_req_i  in  1  refill request, held until accepted.
- rd_addr_i  in  32  line address; bits [3:0] are forced to zero.
- rd_ready_o  out  1  accept strobe for the read request.
- rd_valid_o  out  1  one-cycle pulse; rd_data_o is valid in this cycle.
- rd_data_o  out  128  refilled line; beat n lands in [32n+31:32n].
- err_o  out  1  one-cycle pulse together with wr_done_o/rd_valid_o when that transfer failed.
- outport_aw{valid,addr,id,len,burst}_o  out  1/32/5/8/2  write address channel.
- outport_awready_i  in  1  write address accept.
- outport_w{valid,data,strb,last}_o  out  1/32/4/1  write data channel.
- outport_wready_i  in  1  write data accept.
- outport_bvalid_i, outport_bresp_i[1:0], outport_bid_i[4:0]  in  write response.
- outport_bready_o  out  1  write response accept.
- outport_ar{valid,addr,id,len,burst}_o  out  1/32/5/8/2  read address channel.
- outport_arready_i  in  1  read address accept.
- outport_r{valid,data,resp,id,last}_i  in  1/32/2/5/1  read data channel.
- outport_rready_o  out  1  read data accept.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, DONE.
- Request selection in IDLE:
  - wr_ready_o = IDLE & wr_req_i.
  - rd_ready_o = IDLE & rd_req_i & !wr_req_i. Writeback has priority.
  - Both ready outputs are combinational and are 0 while rst_ni is low.
- On accept, capture the address (low 4 bits zeroed), data and strobes. A write goes to WR_REQ; a read goes to RD_ADDR.
- Burst attributes: awlen/arlen = 3, awburst/arburst = 2'b01, IDs = AXI_ID.
- WR_REQ:
  - awvalid and wvalid are both asserted on entry. awvalid drops after the awready handshake.
  - A 2-bit beat counter selects wdata/wstrb. wlast = (beat == 3). wvalid drops after the beat-3 handshake.
  - Leave for WR_RESP once both the AW handshake and all 4 W handshakes have completed, in any relative order.
- WR_RESP: bready = 1. On bvalid, set the error flag if bresp != 0, then go to DONE.
- RD_ADDR: arvalid = 1. Go to RD_DATA on arready.
- RD_DATA:
  - rready = 1. Each rvalid beat is written into line word [beat] and beat increments.
  - The error flag is set by any rresp != 0, by rlast on beat < 3, or by no rlast on beat 3.
  - Leave for DONE on the beat where rlast = 1 or beat = 3, whichever comes first.
- DONE:
  - Pulse wr_done_o or rd_valid_o for the finished type, with err_o = error flag.
  - Clear the error flag and return to IDLE.
- rid and bid are not checked. Only one transaction is outstanding at any time.

## Timing
- Reset values: state IDLE. All *valid_o, bready, rready, wr_done_o, rd_valid_o and err_o are 0. rd_data_o and captured registers are 0.
- Reset asserted mid-burst aborts immediately, with no AXI completion. The downstream controller is reset with it.
- Read latency with zero-wait slaves:
  - accept at cycle 0, arvalid at 1, beats at 2–5 (rdata arriving one per cycle).
  - rd_valid_o at 6.
- Write latency with zero-wait slaves:
  - accept at 0; AW and W beat 0 at 1; beats 1–3 at 2–4.
  - Earliest bvalid at 5, wr_done_o at 6.
- AXI valids never drop before their handshake, and address/data stay stable while valid is high.
- rd_data_o holds its value until the next read completes.
- The earliest next accept is the cycle after DONE, when the state is IDLE.

## Test plan
- Read 0x0000_1004, slave returns 11,22,33,44 with zero wait:
  - araddr = 0x0000_1000, arlen = 3.
  - rd_data_o = 0x00000044_00000033_00000022_00000011 at cycle 6; err_o = 0.
- Write 0x2000, data words A0..A3, wr_strb_i = 16'hF0FF, with awready delayed 3 cycles after wvalid beats complete:
  - 4 W beats with wstrb F,F,0,F and wlast only on beat 3.
  - AW issued once; wr_done_o pulses once after bvalid.
- wr_req_i and rd_req_i raised in the same cycle:
  - wr_ready_o = 1 and rd_ready_o = 0.
  - The read is accepted in the cycle after the write's DONE.
- Random rvalid/awready/wready/bvalid stalls over 200 transactions: the data scoreboard matches and no valid drops before its handshake.
- rresp = 2'b10 on beat 1:
  - All 4 beats are consumed.
  - rd_valid_o and err_o pulse together; the next transfer has err_o = 0.
- rst_ni pulsed low during read beat 2:
  - All outputs go to reset values asynchronously.
  - After release, a fresh read completes correctly.
